// File: rtl/dispatch_queue.sv
// dispatch_queue: FIFO of decoded instructions issuing one per cycle
// to RS/LSB/RoB/RF with CDB bypass and back-to-back hazard forwarding.
module dispatch_queue #(
  parameter int IQ_WIDTH  = 2,
  parameter int RoB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 new_instruction_en,
  input  logic [31:0]          new_pc,
  input  logic [31:0]          new_imm,
  input  logic [6:0]           new_opcode,
  input  logic [4:0]           new_rs1,
  input  logic [4:0]           new_rs2,
  input  logic [4:0]           new_rd,
  input  logic                 new_predict_result,
  output logic                 new_instruction_able,
  input  logic                 RS_isFull,
  input  logic                 LSB_isFull,
  input  logic                 RoB_isFull,
  input  logic                 RoB_flush_signal,
  input  logic                 cdb_en,
  input  logic [RoB_WIDTH-1:0] cdb_rob_index,
  input  logic [31:0]          cdb_value,
  output logic [4:0]           RF_rs1,
  output logic [4:0]           RF_rs2,
  input  logic [RoB_WIDTH:0]   RF_Qj,
  input  logic [RoB_WIDTH:0]   RF_Qk,
  input  logic [31:0]          RF_Vj,
  input  logic [31:0]          RF_Vk,
  output logic                 RS_en,
  output logic                 LSB_en,
  output logic                 RoB_en,
  output logic                 RF_en,
  output logic [RoB_WIDTH-1:0] iss_rob_index,
  output logic [6:0]           iss_opcode,
  output logic [31:0]          iss_Vj,
  output logic [31:0]          iss_Vk,
  output logic [31:0]          iss_imm,
  output logic [31:0]          iss_pc,
  output logic [RoB_WIDTH:0]   iss_Qj,
  output logic [RoB_WIDTH:0]   iss_Qk,
  output logic [4:0]           iss_rd,
  output logic [31:0]          iss_next_pc,
  output logic                 iss_predict,
  output logic                 iss_ready,
  output logic [31:0]          iss_ready_data
);

  localparam int DEPTH = 1 << IQ_WIDTH;
  localparam logic [IQ_WIDTH:0] FULL = (IQ_WIDTH+1)'(DEPTH);
  localparam logic [RoB_WIDTH:0] NON_DEP =
    (RoB_WIDTH+1)'(1 << RoB_WIDTH);

  logic [31:0]          r_pc   [DEPTH];
  logic [31:0]          r_imm  [DEPTH];
  logic [6:0]           r_op   [DEPTH];
  logic [4:0]           r_rs1  [DEPTH];
  logic [4:0]           r_rs2  [DEPTH];
  logic [4:0]           r_rd   [DEPTH];
  logic                 r_pred [DEPTH];
  logic [IQ_WIDTH-1:0]  r_head;
  logic [IQ_WIDTH-1:0]  r_tail;
  logic [IQ_WIDTH:0]    r_count;
  logic [RoB_WIDTH-1:0] r_rob;

  logic [6:0]  w_op;
  logic [31:0] w_pc, w_imm, w_pc_imm, w_pc_4;
  logic [4:0]  w_rd;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st;
  logic w_ialu, w_ralu, w_valid, w_noreg;
  logic w_to_rs, w_to_lsb, w_use_rs2, w_wr_rd;
  logic w_push, w_pop, w_issue, w_blocked;
  logic [RoB_WIDTH:0] w_qj, w_qk;
  logic [31:0] w_vj, w_vk;

  assign w_op     = r_op[r_head];
  assign w_pc     = r_pc[r_head];
  assign w_imm    = r_imm[r_head];
  assign w_rd     = r_rd[r_head];
  assign w_pc_imm = w_pc + w_imm;
  assign w_pc_4   = w_pc + 32'd4;

  assign w_lui   = w_op == 7'd1;
  assign w_auipc = w_op == 7'd2;
  assign w_jal   = w_op == 7'd3;
  assign w_jalr  = w_op == 7'd4;
  assign w_br    = w_op >= 7'd5  && w_op <= 7'd10;
  assign w_ld    = w_op >= 7'd11 && w_op <= 7'd15;
  assign w_st    = w_op >= 7'd16 && w_op <= 7'd18;
  assign w_ialu  = w_op >= 7'd19 && w_op <= 7'd27;
  assign w_ralu  = w_op >= 7'd28 && w_op <= 7'd37;
  assign w_valid = w_op != 7'd0 && w_op <= 7'd37;
  assign w_noreg = w_lui || w_auipc || w_jal;

  assign w_to_rs   = w_jalr || w_br || w_ialu || w_ralu;
  assign w_to_lsb  = w_ld || w_st;
  assign w_use_rs2 = w_br || w_st || w_ralu;
  assign w_wr_rd   = w_noreg || w_jalr || w_ld || w_ialu || w_ralu;

  assign RF_rs1 = w_noreg ? 5'd0 : r_rs1[r_head];
  assign RF_rs2 = w_use_rs2 ? r_rs2[r_head] : 5'd0;

  assign new_instruction_able = r_count < FULL;
  assign w_push = new_instruction_en && (r_count < FULL);

  // Invalid opcodes need no unit, so they drain without waiting.
  assign w_blocked = RoB_isFull
                  || (w_to_rs && RS_isFull)
                  || (w_to_lsb && LSB_isFull);
  assign w_pop   = (r_count != '0) && (!w_valid || !w_blocked);
  assign w_issue = w_pop && w_valid;

  // Last issue's RF occupation lands one cycle late; forward its tag.
  always_comb begin
    w_qj = RF_Qj;
    w_vj = RF_Vj;
    w_qk = RF_Qk;
    w_vk = RF_Vk;
    if (RF_en && RF_rs1 != 5'd0 && RF_rs1 == iss_rd) begin
      w_qj = {1'b0, iss_rob_index};
      w_vj = '0;
    end else if (RF_Qj != NON_DEP && cdb_en
                 && cdb_rob_index == RF_Qj[RoB_WIDTH-1:0]) begin
      w_qj = NON_DEP;
      w_vj = cdb_value;
    end
    if (RF_en && RF_rs2 != 5'd0 && RF_rs2 == iss_rd) begin
      w_qk = {1'b0, iss_rob_index};
      w_vk = '0;
    end else if (RF_Qk != NON_DEP && cdb_en
                 && cdb_rob_index == RF_Qk[RoB_WIDTH-1:0]) begin
      w_qk = NON_DEP;
      w_vk = cdb_value;
    end
    if (!w_use_rs2) begin
      w_qk = NON_DEP;
      w_vk = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && !RoB_flush_signal && rdy_in && w_push) begin
      r_pc[r_tail]   <= new_pc;
      r_imm[r_tail]  <= new_imm;
      r_op[r_tail]   <= new_opcode;
      r_rs1[r_tail]  <= new_rs1;
      r_rs2[r_tail]  <= new_rs2;
      r_rd[r_tail]   <= new_rd;
      r_pred[r_tail] <= new_predict_result;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_rob          <= '0;
      RS_en          <= 1'b0;
      LSB_en         <= 1'b0;
      RoB_en         <= 1'b0;
      RF_en          <= 1'b0;
      iss_rob_index  <= '0;
      iss_opcode     <= '0;
      iss_Vj         <= '0;
      iss_Vk         <= '0;
      iss_imm        <= '0;
      iss_pc         <= '0;
      iss_Qj         <= '0;
      iss_Qk         <= '0;
      iss_rd         <= '0;
      iss_next_pc    <= '0;
      iss_predict    <= 1'b0;
      iss_ready      <= 1'b0;
      iss_ready_data <= '0;
    end else if (RoB_flush_signal) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rob   <= '0;
      RS_en   <= 1'b0;
      LSB_en  <= 1'b0;
      RoB_en  <= 1'b0;
      RF_en   <= 1'b0;
    end else if (rdy_in) begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      RoB_en <= w_issue;
      RS_en  <= w_issue && w_to_rs;
      LSB_en <= w_issue && w_to_lsb;
      RF_en  <= w_issue && w_wr_rd && (w_rd != 5'd0);
      if (w_issue) begin
        r_rob          <= r_rob + 1'b1;
        iss_rob_index  <= r_rob;
        iss_opcode     <= w_op;
        iss_Vj         <= w_vj;
        iss_Vk         <= w_vk;
        iss_Qj         <= w_qj;
        iss_Qk         <= w_qk;
        iss_imm        <= w_ralu ? 32'd0 : w_imm;
        iss_pc         <= w_pc;
        iss_rd         <= (w_br || w_st) ? 5'd0 : w_rd;
        iss_next_pc    <= (w_jal || w_br) ? w_pc_imm : w_pc_4;
        iss_predict    <= w_br && r_pred[r_head];
        iss_ready      <= w_noreg;
        iss_ready_data <= w_lui   ? w_imm :
                          w_auipc ? w_pc_imm :
                          w_jal   ? w_pc_4 : 32'd0;
      end
    end
  end

endmodule
